// File: rtl/hamming_byte_tx.sv
// hamming_byte_tx: framed serial transmitter sharing one (7,4) Hamming encoder across both nibbles of a byte

module hamming_code (
    input  logic [3:0] data,
    output logic [6:0] code
);
    assign code = {data[3], data[2], data[1], data[1] ^ data[2] ^ data[3],
                   data[0], data[0] ^ data[2] ^ data[3], data[0] ^ data[1] ^ data[3]};
endmodule

module hamming_byte_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       frame_done
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, HI, LO, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bitc, bitc_n;
    logic [6:0]    sh, sh_n, code;
    logic [7:0]    cap, cap_n;
    logic          tx_n, done_n, last;

    hamming_code u_enc (
        .data(state == START ? cap[7:4] : cap[3:0]),
        .code(code)
    );

    assign last = baud == BW'(CLKS_PER_BIT - 1);

    // next-state, counters, shift register and registered-output precompute
    always_comb begin
        state_n = state;
        baud_n  = last ? '0 : baud + 1'b1;
        bitc_n  = bitc;
        sh_n    = sh;
        cap_n   = cap;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (in_valid && in_ready) begin
                    state_n = START;
                    cap_n   = in_data;
                end
            end
            START: if (last) begin
                state_n = HI;
                sh_n    = code;
                bitc_n  = 3'd6;
            end
            HI: if (last) begin
                if (bitc == 3'd0) begin
                    state_n = LO;
                    sh_n    = code;
                    bitc_n  = 3'd6;
                end else begin
                    sh_n   = sh << 1;
                    bitc_n = bitc - 3'd1;
                end
            end
            LO: if (last) begin
                if (bitc == 3'd0) begin
                    state_n = STOP;
                end else begin
                    sh_n   = sh << 1;
                    bitc_n = bitc - 3'd1;
                end
            end
            STOP: if (last) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START ? 1'b0 : (state_n == HI || state_n == LO) ? sh_n[6] : 1'b1;
    end

    // state and registered outputs; line returns high the instant reset asserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud       <= '0;
            bitc       <= '0;
            sh         <= '0;
            cap        <= '0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bitc       <= bitc_n;
            sh         <= sh_n;
            cap        <= cap_n;
            tx_serial  <= tx_n;
            tx_busy    <= state_n != IDLE;
            frame_done <= done_n;
            in_ready   <= state_n == IDLE;
        end
    end
endmodule
